// File: rtl/ps2_key_event_gen_pkg.sv
// Shared byte constants, event word type and parser states for the PS/2 key event generator.
package ps2_key_event_gen_pkg;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_E1 = 8'hE1;
  localparam logic [7:0] PS2_AA = 8'hAA;
  localparam logic [7:0] PS2_FA = 8'hFA;
  localparam logic [7:0] PS2_FE = 8'hFE;
  localparam logic [7:0] PS2_EE = 8'hEE;
  localparam logic [7:0] PS2_00 = 8'h00;
  localparam logic [7:0] PS2_FF = 8'hFF;

  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_evt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_PSKIP
  } ps2_state_e;

  // Keyboard replies and status bytes that never describe a key.
  function automatic logic is_reply_byte(input logic [7:0] b);
    return (b == PS2_AA) || (b == PS2_FA) || (b == PS2_FE) ||
           (b == PS2_EE) || (b == PS2_00) || (b == PS2_FF);
  endfunction

endpackage

// File: rtl/ps2_key_event_gen_if.sv
// Byte handshake from the PS/2 serial receiver into the key event generator.
interface ps2_key_event_gen_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/ps2_key_event_gen_fifo.sv
// Small synchronous FIFO of decoded key events; push and pop may coincide at any level, even full.
module ps2_key_event_gen_fifo
  import ps2_key_event_gen_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     i_push,
  input  ps2_evt_t                 i_data,
  input  logic                     i_pop,
  output ps2_evt_t                 o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  ps2_evt_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_level == LEVEL_FULL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk_sys) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + LEVEL_ONE;
      end else if (!w_do_push && w_do_pop) begin
        r_level <= r_level - LEVEL_ONE;
      end
    end
  end

endmodule

// File: rtl/ps2_key_event_gen.sv
// Parses PS/2 scan-code bytes into toggle-strobed ps2_key event words, buffered and rate-limited.
module ps2_key_event_gen
  import ps2_key_event_gen_pkg::*;
#(
  parameter int         DEPTH      = 4,
  parameter int         MIN_GAP    = 16,
  parameter int         TIMEOUT    = 65535,
  parameter logic [8:0] PAUSE_CODE = 9'h177
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  ps2_key_event_gen_if.slave      rx,
  output logic [10:0]             ps2_key,
  output logic [$clog2(DEPTH):0]  evt_level
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(MIN_GAP);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE     = TO_W'(1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);

  ps2_state_e       r_state;
  logic             r_ext;
  logic [2:0]       r_skip_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [GAP_W-1:0] r_gap;
  logic [10:0]      r_ps2_key;

  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_byte;
  ps2_evt_t         w_evt;
  ps2_evt_t         w_head;

  assign w_byte      = rx.rx_data;
  assign rx.rx_ready = !reset && !w_full;
  assign w_accept    = rx.rx_valid && rx.rx_ready;
  assign w_pop       = !w_empty && (r_gap == '0);
  assign ps2_key     = r_ps2_key;

  // Decide whether the byte being accepted completes a key event.
  always_comb begin
    w_push = 1'b0;
    w_evt  = '0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (w_byte != PS2_E0 && w_byte != PS2_F0 && w_byte != PS2_E1 &&
              !is_reply_byte(w_byte)) begin
            w_push = 1'b1;
            w_evt  = '{pressed: 1'b1, ext: 1'b0, code: w_byte};
          end
        end
        ST_EXT: begin
          if (w_byte != PS2_E0 && w_byte != PS2_F0 && w_byte != PS2_E1) begin
            w_push = 1'b1;
            w_evt  = '{pressed: 1'b1, ext: 1'b1, code: w_byte};
          end
        end
        ST_BRK: begin
          if (w_byte != PS2_E0 && w_byte != PS2_F0 && w_byte != PS2_E1) begin
            w_push = 1'b1;
            w_evt  = '{pressed: 1'b0, ext: r_ext, code: w_byte};
          end
        end
        ST_PSKIP: begin
          if (r_skip_cnt == 3'd1) begin
            w_push = 1'b1;
            w_evt  = '{pressed: 1'b1, ext: PAUSE_CODE[8], code: PAUSE_CODE[7:0]};
          end
        end
        default: begin
          w_push = 1'b0;
        end
      endcase
    end
  end

  // Parser FSM; a stalled prefix sequence is abandoned after TIMEOUT idle cycles.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ext      <= 1'b0;
      r_skip_cnt <= '0;
      r_to_cnt   <= '0;
    end else if (w_accept) begin
      r_to_cnt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_byte == PS2_E0) begin
            r_state <= ST_EXT;
          end else if (w_byte == PS2_F0) begin
            r_state <= ST_BRK;
            r_ext   <= 1'b0;
          end else if (w_byte == PS2_E1) begin
            r_state    <= ST_PSKIP;
            r_skip_cnt <= 3'd7;
          end
        end
        ST_EXT: begin
          if (w_byte == PS2_F0) begin
            r_state <= ST_BRK;
            r_ext   <= 1'b1;
          end else if (w_byte == PS2_E1) begin
            r_state    <= ST_PSKIP;
            r_skip_cnt <= 3'd7;
          end else if (w_byte != PS2_E0) begin
            r_state <= ST_IDLE;
          end
        end
        ST_BRK: begin
          r_state <= ST_IDLE;
        end
        ST_PSKIP: begin
          if (r_skip_cnt == 3'd1) begin
            r_state <= ST_IDLE;
          end else begin
            r_skip_cnt <= r_skip_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end else if (r_state != ST_IDLE) begin
      if (r_to_cnt == TO_LAST) begin
        r_state  <= ST_IDLE;
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_ONE;
      end
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Present one event per pop and hold off the next until MIN_GAP cycles have passed.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_ps2_key <= '0;
      r_gap     <= '0;
    end else if (w_pop) begin
      r_ps2_key <= {~r_ps2_key[10], w_head};
      r_gap     <= GAP_RELOAD;
    end else if (r_gap != '0) begin
      r_gap <= r_gap - GAP_ONE;
    end
  end

  ps2_key_event_gen_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_evt),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (evt_level)
  );

endmodule

// File: tb/tb_ps2_key_event_gen.sv
// Scoreboard bench for ps2_key_event_gen: expected words queued at stimulus, popped on each toggle.
module tb_ps2_key_event_gen;

  localparam int DEPTH   = 4;
  localparam int MIN_GAP = 16;
  localparam int TIMEOUT = 64;

  logic                   clk_sys = 1'b0;
  logic                   reset   = 1'b1;
  logic [10:0]            ps2_key;
  logic [$clog2(DEPTH):0] evt_level;

  ps2_key_event_gen_if rxIf();

  ps2_key_event_gen #(
    .DEPTH      (DEPTH),
    .MIN_GAP    (MIN_GAP),
    .TIMEOUT    (TIMEOUT),
    .PAUSE_CODE (9'h177)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .rx        (rxIf),
    .ps2_key   (ps2_key),
    .evt_level (evt_level)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int passes = 0;
  int cycleCnt = 0;
  int toggleCount = 0;
  int lastToggleCycle = 0;
  int lastDriveCycle = 0;
  int minGap = 1000;
  int maxGap = 0;
  int maxLevel = 0;
  int gapSeen;
  logic havePrevToggle = 1'b0;
  logic sawNotReady = 1'b0;
  logic prevToggle = 1'b0;
  logic [9:0] expKey;
  logic [9:0] expQ[$];

  always @(posedge clk_sys) cycleCnt <= cycleCnt + 1;

  // Scoreboard monitor: every toggle must match the oldest outstanding expected word.
  always @(negedge clk_sys) begin
    if (reset) begin
      prevToggle = ps2_key[10];
    end else if (ps2_key[10] !== prevToggle) begin
      prevToggle = ps2_key[10];
      toggleCount++;
      if (havePrevToggle) begin
        gapSeen = cycleCnt - lastToggleCycle;
        if (gapSeen < minGap) minGap = gapSeen;
        if (gapSeen > maxGap) maxGap = gapSeen;
      end
      lastToggleCycle = cycleCnt;
      havePrevToggle = 1'b1;
      checks++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL unexpected_toggle: got %h, expected no event", ps2_key[9:0]);
      end else begin
        expKey = expQ.pop_front();
        if (ps2_key[9:0] !== expKey) begin
          $display("[TB] FAIL event_word: got %h, expected %h", ps2_key[9:0], expKey);
        end else begin
          passes++;
        end
      end
    end
    if (!reset && int'(evt_level) > maxLevel) maxLevel = int'(evt_level);
    if (!reset && rxIf.rx_valid && !rxIf.rx_ready) sawNotReady = 1'b1;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Drive one byte and hold it until the DUT takes it; returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] b);
    int waitCnt = 0;
    rxIf.rx_data  = b;
    rxIf.rx_valid = 1'b1;
    lastDriveCycle = cycleCnt;
    @(negedge clk_sys);
    while (!rxIf.rx_ready && waitCnt < 300) begin
      @(negedge clk_sys);
      waitCnt++;
    end
    if (!rxIf.rx_ready) begin
      checks++;
      $display("[TB] FAIL rx_accept_timeout: rx_ready=%b, expected 1 for byte %h", rxIf.rx_ready, b);
    end
    @(posedge clk_sys);
    #1;
    rxIf.rx_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 1000) begin
      @(negedge clk_sys);
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      $display("[TB] FAIL %s_drain: %0d events outstanding, expected 0", name, expQ.size());
      expQ.delete();
    end
    waitCycles(MIN_GAP + 4);
  endtask

  task automatic test_reset();
    waitCycles(2);
    @(negedge clk_sys);
    checks++;
    if (rxIf.rx_ready !== 1'b0) $display("[TB] FAIL reset_rx_ready: got %b, expected 0", rxIf.rx_ready);
    else passes++;
    checks++;
    if (ps2_key !== 11'h000) $display("[TB] FAIL reset_ps2_key: got %h, expected 000", ps2_key);
    else passes++;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (rxIf.rx_ready !== 1'b1) $display("[TB] FAIL post_reset_rx_ready: got %b, expected 1", rxIf.rx_ready);
    else passes++;
    checks++;
    if (evt_level !== '0) $display("[TB] FAIL reset_evt_level: got %0d, expected 0", evt_level);
    else passes++;
    waitCycles(1);
  endtask

  task automatic test_make_break();
    int startToggles = toggleCount;
    expQ.push_back(10'h21C);
    applyStimulus(8'h1C);
    waitDrain("make");
    checks++;
    if (lastToggleCycle - lastDriveCycle !== 2)
      $display("[TB] FAIL make_latency: got %0d cycles, expected 2", lastToggleCycle - lastDriveCycle);
    else passes++;
    expQ.push_back(10'h01C);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    waitDrain("break");
    checks++;
    if (toggleCount - startToggles !== 2)
      $display("[TB] FAIL make_break_toggles: got %0d, expected 2", toggleCount - startToggles);
    else passes++;
  endtask

  task automatic test_extended();
    expQ.push_back(10'h375);
    applyStimulus(8'hE0);
    applyStimulus(8'h75);
    expQ.push_back(10'h175);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h75);
    waitDrain("extended");
    checks++;
    if (ps2_key[9:0] !== 10'h175) $display("[TB] FAIL ext_break_hold: got %h, expected 175", ps2_key[9:0]);
    else passes++;
  endtask

  task automatic test_pause_and_replies();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    int startToggles = toggleCount;
    expQ.push_back(10'h377);
    for (int i = 0; i < 8; i++) applyStimulus(seq[i]);
    applyStimulus(8'hAA);
    applyStimulus(8'hFA);
    waitDrain("pause");
    checks++;
    if (toggleCount - startToggles !== 1)
      $display("[TB] FAIL pause_toggles: got %0d, expected 1", toggleCount - startToggles);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int startToggles = toggleCount;
    havePrevToggle = 1'b0;
    minGap = 1000;
    maxGap = 0;
    maxLevel = 0;
    sawNotReady = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      expQ.push_back({2'b10, 8'(8'h15 + i)});
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      applyStimulus(8'(8'h15 + i));
    end
    waitDrain("back_to_back");
    checks++;
    if (sawNotReady !== 1'b1) $display("[TB] FAIL b2b_ready_drop: got %b, expected 1", sawNotReady);
    else passes++;
    checks++;
    if (maxLevel !== DEPTH) $display("[TB] FAIL b2b_max_level: got %0d, expected %0d", maxLevel, DEPTH);
    else passes++;
    checks++;
    if (minGap !== MIN_GAP || maxGap !== MIN_GAP)
      $display("[TB] FAIL b2b_gap: got min %0d max %0d, expected %0d", minGap, maxGap, MIN_GAP);
    else passes++;
    checks++;
    if (toggleCount - startToggles !== DEPTH + 2)
      $display("[TB] FAIL b2b_toggles: got %0d, expected %0d", toggleCount - startToggles, DEPTH + 2);
    else passes++;
  endtask

  task automatic test_timeout();
    expQ.push_back(10'h329);
    applyStimulus(8'hE0);
    waitCycles(TIMEOUT - 3);
    applyStimulus(8'h29);
    waitDrain("before_timeout");
    expQ.push_back(10'h229);
    applyStimulus(8'hE0);
    waitCycles(TIMEOUT + 4);
    applyStimulus(8'h29);
    waitDrain("timeout");
    expQ.push_back(10'h216);
    applyStimulus(8'hF0);
    applyStimulus(8'hE0);
    applyStimulus(8'h16);
    waitDrain("malformed_break");
  endtask

  task automatic test_reset_mid();
    logic [7:0] codes [4] = '{8'h1A, 8'h1B, 8'h1C, 8'h1D};
    for (int i = 0; i < 4; i++) expQ.push_back({2'b10, codes[i]});
    for (int i = 0; i < 4; i++) applyStimulus(codes[i]);
    applyStimulus(8'hF0);
    @(negedge clk_sys);
    checks++;
    if (evt_level !== 3'd3) $display("[TB] FAIL mid_level: got %0d, expected 3", evt_level);
    else passes++;
    @(posedge clk_sys);
    #1;
    reset = 1'b1;
    expQ.delete();
    waitCycles(2);
    @(negedge clk_sys);
    checks++;
    if (ps2_key !== 11'h000 || evt_level !== '0)
      $display("[TB] FAIL mid_reset: got key %h level %0d, expected 000 and 0", ps2_key, evt_level);
    else passes++;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    waitCycles(1);
    expQ.push_back(10'h216);
    applyStimulus(8'h16);
    waitDrain("after_reset");
  endtask

  initial begin
    rxIf.rx_data  = 8'h00;
    rxIf.rx_valid = 1'b0;
    test_reset();
    test_make_break();
    test_extended();
    test_pause_and_replies();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    checks++;
    if (expQ.size() !== 0) $display("[TB] FAIL scoreboard_empty: got %0d left, expected 0", expQ.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
